// File: rtl/pw_trigger_sequencer_if.sv
// Bundles the register-block settings, matcher handshake and trigger outputs of the
// trigger sequencer; master is the driving side, slave is the sequencer itself.
interface pw_trigger_sequencer_if #(
    parameter int pDELAY_WIDTH = 20,
    parameter int pWIDTH_WIDTH = 17,
    parameter int pCOUNT_WIDTH = 8
);
    logic                    I_arm;
    logic [pDELAY_WIDTH-1:0] I_delay;
    logic [pWIDTH_WIDTH-1:0] I_width;
    logic [pWIDTH_WIDTH-1:0] I_gap;
    logic [pCOUNT_WIDTH-1:0] I_num_pulses;
    logic                    I_match_trigger;
    logic                    O_matcher_arm;
    logic                    O_trigger;
    logic                    O_armed;
    logic                    O_busy;
    logic                    O_done;
    logic [pCOUNT_WIDTH-1:0] O_pulse_count;

    modport master (
        output I_arm, I_delay, I_width, I_gap, I_num_pulses, I_match_trigger,
        input  O_matcher_arm, O_trigger, O_armed, O_busy, O_done, O_pulse_count
    );

    modport slave (
        input  I_arm, I_delay, I_width, I_gap, I_num_pulses, I_match_trigger,
        output O_matcher_arm, O_trigger, O_armed, O_busy, O_done, O_pulse_count
    );
endinterface

// File: rtl/pw_trigger_sequencer.sv
// Arms the pattern matcher, then turns a match into a delayed, programmable train of
// trigger pulses; one-shot per I_arm rising edge, aborted whenever I_arm drops.
module pw_trigger_sequencer #(
    parameter int pDELAY_WIDTH = 20,
    parameter int pWIDTH_WIDTH = 17,
    parameter int pCOUNT_WIDTH = 8
) (
    input  logic                   trigger_clk,
    input  logic                   reset_i,
    pw_trigger_sequencer_if.slave  bus
);
    typedef enum logic [2:0] {IDLE, ARMED, DELAY, PULSE, GAP, DONE} state_t;

    localparam logic [pDELAY_WIDTH-1:0] D_ONE = pDELAY_WIDTH'(1);
    localparam logic [pWIDTH_WIDTH-1:0] W_ONE = pWIDTH_WIDTH'(1);
    localparam logic [pCOUNT_WIDTH-1:0] C_ONE = pCOUNT_WIDTH'(1);

    state_t                  state_q, state_d;
    logic                    armPrev_q;
    logic                    trigger_q;
    logic [pDELAY_WIDTH-1:0] delay_q;
    logic [pWIDTH_WIDTH-1:0] width_q, gap_q;
    logic [pCOUNT_WIDTH-1:0] num_q;
    logic [pDELAY_WIDTH-1:0] delayCnt_q, delayCnt_d;
    logic [pWIDTH_WIDTH-1:0] phaseCnt_q, phaseCnt_d;
    logic [pCOUNT_WIDTH-1:0] pulseCnt_q, pulseCnt_d;
    logic                    armRise;

    assign armRise = bus.I_arm & ~armPrev_q;

    always_ff @(posedge trigger_clk or posedge reset_i) begin
        if (reset_i) begin
            state_q    <= IDLE;
            armPrev_q  <= 1'b0;
            trigger_q  <= 1'b0;
            delayCnt_q <= '0;
            phaseCnt_q <= '0;
            pulseCnt_q <= '0;
        end else begin
            state_q    <= state_d;
            armPrev_q  <= bus.I_arm;
            trigger_q  <= (state_d == PULSE);
            delayCnt_q <= delayCnt_d;
            phaseCnt_q <= phaseCnt_d;
            pulseCnt_q <= pulseCnt_d;
        end
    end

    // Settings are captured only at arming so register writes cannot disturb a sequence in flight.
    always_ff @(posedge trigger_clk or posedge reset_i) begin
        if (reset_i) begin
            delay_q <= '0;
            width_q <= W_ONE;
            gap_q   <= W_ONE;
            num_q   <= C_ONE;
        end else if (state_q == IDLE && armRise) begin
            delay_q <= bus.I_delay;
            width_q <= (bus.I_width == '0) ? W_ONE : bus.I_width;
            gap_q   <= (bus.I_gap == '0) ? W_ONE : bus.I_gap;
            num_q   <= (bus.I_num_pulses == '0) ? C_ONE : bus.I_num_pulses;
        end
    end

    always_comb begin
        state_d    = state_q;
        delayCnt_d = delayCnt_q;
        phaseCnt_d = phaseCnt_q;
        pulseCnt_d = pulseCnt_q;
        case (state_q)
            IDLE: begin
                if (armRise) begin
                    state_d    = ARMED;
                    pulseCnt_d = '0;
                end
            end
            ARMED: begin
                if (bus.I_match_trigger) begin
                    if (delay_q == '0) begin
                        state_d    = PULSE;
                        phaseCnt_d = width_q - W_ONE;
                    end else begin
                        state_d    = DELAY;
                        delayCnt_d = delay_q - D_ONE;
                    end
                end
            end
            DELAY: begin
                if (delayCnt_q == '0) begin
                    state_d    = PULSE;
                    phaseCnt_d = width_q - W_ONE;
                end else begin
                    delayCnt_d = delayCnt_q - D_ONE;
                end
            end
            PULSE: begin
                if (phaseCnt_q == '0) begin
                    pulseCnt_d = pulseCnt_q + C_ONE;
                    if (pulseCnt_q < num_q - C_ONE) begin
                        state_d    = GAP;
                        phaseCnt_d = gap_q - W_ONE;
                    end else begin
                        state_d = DONE;
                    end
                end else begin
                    phaseCnt_d = phaseCnt_q - W_ONE;
                end
            end
            GAP: begin
                if (phaseCnt_q == '0) begin
                    state_d    = PULSE;
                    phaseCnt_d = width_q - W_ONE;
                end else begin
                    phaseCnt_d = phaseCnt_q - W_ONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // Abort beats every other transition, including a same-edge match or pulse completion.
        if (state_q != IDLE && !bus.I_arm) begin
            state_d    = IDLE;
            pulseCnt_d = pulseCnt_q;
        end
    end

    assign bus.O_trigger     = trigger_q;
    assign bus.O_armed       = (state_q == ARMED);
    assign bus.O_matcher_arm = (state_q == ARMED);
    assign bus.O_busy        = (state_q == DELAY) || (state_q == PULSE) || (state_q == GAP);
    assign bus.O_done        = (state_q == DONE);
    assign bus.O_pulse_count = pulseCnt_q;
endmodule

// File: tb/tb_pw_trigger_sequencer.sv
// Drives directed and randomized arm/match sequences and compares every cycle against a
// timeline model built from the delay/width/gap/count arithmetic of the trigger train.
module tb_pw_trigger_sequencer;
    localparam int DW = 20;
    localparam int WW = 17;
    localparam int CW = 8;

    logic trigger_clk = 1'b0;
    logic reset_i;
    int   checkCount  = 0;
    int   passCount   = 0;

    pw_trigger_sequencer_if #(.pDELAY_WIDTH(DW), .pWIDTH_WIDTH(WW), .pCOUNT_WIDTH(CW)) bus ();

    pw_trigger_sequencer #(.pDELAY_WIDTH(DW), .pWIDTH_WIDTH(WW), .pCOUNT_WIDTH(CW)) dut (
        .trigger_clk (trigger_clk),
        .reset_i     (reset_i),
        .bus         (bus.slave)
    );

    always #5 trigger_clk = ~trigger_clk;

    // Trigger is high at t cycles after the match edge when t falls inside any pulse window.
    function automatic int trigAt(input int t, input int d, input int w, input int g, input int n);
        for (int k = 0; k < n; k++)
            if (t >= d + k * (w + g) && t < d + k * (w + g) + w) return 1;
        return 0;
    endfunction

    function automatic int countAt(input int t, input int d, input int w, input int g, input int n);
        int c = 0;
        for (int k = 0; k < n; k++)
            if (t >= d + k * (w + g) + w) c++;
        return c;
    endfunction

    task automatic tick();
        @(posedge trigger_clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        assert (observed === expected) passCount++;
        else $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    endtask

    task automatic checkAll(input string tag, input int trig, input int busy, input int done,
                            input int armed, input int count);
        checkOutput({tag, ".trigger"}, 32'(bus.O_trigger), trig);
        checkOutput({tag, ".busy"}, 32'(bus.O_busy), busy);
        checkOutput({tag, ".done"}, 32'(bus.O_done), done);
        checkOutput({tag, ".armed"}, 32'(bus.O_armed), armed);
        checkOutput({tag, ".matcherArm"}, 32'(bus.O_matcher_arm), armed);
        if (count >= 0) checkOutput({tag, ".pulseCount"}, 32'(bus.O_pulse_count), count);
    endtask

    // One full arm/match/train sequence; abortT>0 drops I_arm so the sequencer sees it at that edge.
    task automatic applyStimulus(input int d, input int w, input int g, input int n,
                                 input int preWait, input int abortT, input bit noise);
        int  we, ge, ne, endT, abortCount;
        bit  aborted;
        we   = (w == 0) ? 1 : w;
        ge   = (g == 0) ? 1 : g;
        ne   = (n == 0) ? 1 : n;
        endT = d + (ne - 1) * (we + ge) + we;
        bus.I_delay         = DW'(d);
        bus.I_width         = WW'(w);
        bus.I_gap           = WW'(g);
        bus.I_num_pulses    = CW'(n);
        bus.I_arm           = 1'b0;
        bus.I_match_trigger = 1'b0;
        tick();
        checkAll("idle", 0, 0, 0, 0, -1);
        bus.I_arm = 1'b1;
        tick();
        checkAll("armed", 0, 0, 0, 1, 0);
        if (noise) begin
            bus.I_delay      = DW'($urandom);
            bus.I_width      = WW'($urandom);
            bus.I_gap        = WW'($urandom);
            bus.I_num_pulses = CW'($urandom);
        end
        for (int i = 0; i < preWait; i++) begin
            tick();
            checkAll($sformatf("wait%0d", i), 0, 0, 0, 1, 0);
        end
        bus.I_match_trigger = 1'b1;
        tick();
        bus.I_match_trigger = 1'b0;
        aborted    = 1'b0;
        abortCount = 0;
        for (int t = 0; t <= endT + 4; t++) begin
            if (aborted)
                checkAll($sformatf("abort.t%0d", t), 0, 0, 0, 0, abortCount);
            else
                checkAll($sformatf("seq.t%0d", t), trigAt(t, d, we, ge, ne), (t < endT) ? 1 : 0,
                         (t == endT) ? 1 : 0, 0, countAt(t, d, we, ge, ne));
            if (noise) begin
                bus.I_match_trigger = 1'($urandom_range(0, 1));
                bus.I_delay         = DW'($urandom);
            end
            if (t + 1 == abortT) bus.I_arm = 1'b0;
            tick();
            if (t + 1 == abortT) begin
                aborted    = 1'b1;
                abortCount = countAt(t, d, we, ge, ne);
            end
        end
        bus.I_match_trigger = 1'b0;
    endtask

    initial begin
        bus.I_arm           = 1'b0;
        bus.I_delay         = '0;
        bus.I_width         = '0;
        bus.I_gap           = '0;
        bus.I_num_pulses    = '0;
        bus.I_match_trigger = 1'b0;
        reset_i             = 1'b1;
        #1;
        checkAll("reset", 0, 0, 0, 0, 0);
        tick();
        reset_i = 1'b0;
        tick();
        checkAll("postReset", 0, 0, 0, 0, 0);

        $display("[TB] matches before arming");
        for (int i = 0; i < 3; i++) begin
            bus.I_match_trigger = 1'b1;
            tick();
            bus.I_match_trigger = 1'b0;
            checkAll($sformatf("prearm%0d", i), 0, 0, 0, 0, 0);
        end

        $display("[TB] basic, train, zero settings");
        applyStimulus(5, 3, 0, 1, 2, -1, 1'b0);
        applyStimulus(0, 2, 4, 3, 1, -1, 1'b0);
        applyStimulus(0, 0, 0, 0, 0, -1, 1'b0);

        $display("[TB] abort during second pulse, then re-arm");
        applyStimulus(3, 3, 2, 4, 1, 9, 1'b0);
        applyStimulus(2, 1, 1, 2, 0, -1, 1'b1);

        $display("[TB] shadowing and ignored matches");
        applyStimulus(4, 2, 3, 2, 1, -1, 1'b1);

        $display("[TB] randomized sequences");
        for (int r = 0; r < 12; r++)
            applyStimulus(int'($urandom_range(0, 6)), int'($urandom_range(0, 4)),
                          int'($urandom_range(0, 4)), int'($urandom_range(0, 4)),
                          int'($urandom_range(0, 3)), -1, 1'b1);

        $display("[TB] asynchronous reset during a pulse");
        bus.I_arm           = 1'b0;
        bus.I_delay         = DW'(1);
        bus.I_width         = WW'(2);
        bus.I_gap           = WW'(1);
        bus.I_num_pulses    = CW'(2);
        tick();
        bus.I_arm = 1'b1;
        tick();
        bus.I_match_trigger = 1'b1;
        tick();
        bus.I_match_trigger = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        checkAll("preReset", 1, 1, 0, 0, 1);
        #3;
        reset_i = 1'b1;
        #1;
        checkAll("asyncReset", 0, 0, 0, 0, 0);
        bus.I_arm = 1'b0;
        #1;
        reset_i = 1'b0;
        tick();
        checkAll("afterAsyncReset", 0, 0, 0, 0, 0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end
endmodule

// File: doc/pw_trigger_sequencer.md
# pw_trigger_sequencer

Sequences the USB pattern matcher and turns its match events into the externally visible trigger output. It arms the matcher on a register-block arm request and waits for a match. On a match it applies a programmable delay, then emits a programmable train of trigger pulses, and disarms once the train completes. It sits between the register block, the pattern matcher and the trigger output pin, entirely in the trigger clock domain.

## Interface
- pDELAY_WIDTH, 20, width of delay setting (cycles)
- pWIDTH_WIDTH, 17, width of pulse-width and gap settings (cycles)
- pCOUNT_WIDTH, 8, width of pulse-count setting
- trigger_clk  in  1  sole clock; all logic on posedge
- reset_i  in  1  asynchronous, active-high reset
- I_arm  in  1  arm level from register block (already synchronous to trigger_clk); rising edge arms, low aborts
- I_delay  in  pDELAY_WIDTH  match-to-first-pulse delay D
- I_width  in  pWIDTH_WIDTH  pulse high time W (0 treated as 1)
- I_gap  in  pWIDTH_WIDTH  low time between pulses G (0 treated as 1)
- I_num_pulses  in  pCOUNT_WIDTH  pulse count N (0 treated as 1)
- I_match_trigger  in  1  single-cycle match pulse from pattern matcher, synchronous to trigger_clk
- O_matcher_arm  out  1  arm to pattern matcher
- O_trigger  out  1  trigger output, registered
- O_armed  out  1  high in ARMED
- O_busy  out  1  high in DELAY, PULSE, GAP
- O_done  out  1  one-cycle pulse at sequence completion
- O_pulse_count  out  pCOUNT_WIDTH  pulses completed since last arm

## Operation
- States: IDLE, ARMED, DELAY, PULSE, GAP, DONE. Reset: IDLE, and all outputs and counters are 0.
- IDLE: an I_arm rising edge (I_arm high, previous sample low) -> ARMED. Arming latches D, W, G and N into shadow registers, applying the 0->1 substitutions, and clears O_pulse_count. Later register writes do not affect the sequence in flight.
- ARMED: O_matcher_arm=O_armed=1. A sampled I_match_trigger -> PULSE if D==0, else DELAY (counter loaded).
- DELAY: counts D cycles -> PULSE.
- PULSE: O_trigger=1 for W cycles. At the end, O_pulse_count increments.
  - Remaining pulses -> GAP.
  - Otherwise -> DONE.
- GAP: O_trigger=0 for G cycles -> PULSE.
- DONE: O_done=1 for one cycle -> IDLE. The sequencer is one-shot: it re-arms only on a new I_arm rising edge, so I_arm must drop and rise again.
- O_matcher_arm is 1 only in ARMED. The matcher is disarmed from the first cycle after a match, and further matches are ignored until re-armed.
- Abort: I_arm sampled low in any non-IDLE state -> IDLE on that edge. O_trigger drops on the same edge, O_done is not asserted, and O_pulse_count holds its value.
- I_match_trigger outside ARMED: ignored. A match and an I_arm fall on the same edge: abort wins.
- An I_arm rising edge while not IDLE cannot occur, because I_arm is already high. A held-high I_arm after DONE does not re-arm.
- Counters are sized to their settings. No wrap is possible because counts load from shadow values and count down to terminal.

## Timing
- I_arm first sampled high at edge A: O_matcher_arm/O_armed high after edge A (1-cycle latency).
- Match sampled at edge M: O_trigger rises after edge M+D and falls after edge M+D+W.
- Pulse k (k=0..N-1) rises after edge M+D+k·(W+G).
- O_done high for exactly the cycle after the last falling edge of O_trigger. O_busy is low during that cycle.
- O_pulse_count updates on the same edge that O_trigger falls.
- Asynchronous reset mid-sequence: all outputs are 0 immediately, independent of the clock.

## Test plan
- Basic: arm, match at edge 10, D=5, W=3, N=1 -> O_trigger high for edges 15–17 (falls after edge 18), O_done one cycle after edge 18, O_pulse_count=1, O_matcher_arm low from edge 11.
- Train: D=0, W=2, G=4, N=3, match at edge M -> rising edges after M, M+6, M+12; each pulse is 2 cycles; O_pulse_count steps 1,2,3; O_done after M+14.
- Zero settings: W=0, G=0, N=0, D=0 -> single 1-cycle pulse right after the match edge, then O_done.
- Abort: N=4 and I_arm dropped during the 2nd pulse -> O_trigger low next edge, O_done never asserted, O_pulse_count=1, state IDLE; a new I_arm rise re-arms.
- Ignore and shadowing:
  - Matches before arming and during DELAY produce no extra pulses.
  - Changing I_delay mid-sequence does not change timing.
  - I_arm held high after DONE does not re-arm.
- Reset: assert reset_i asynchronously during PULSE -> O_trigger, O_busy and O_pulse_count are 0 before the next clock edge.
